// File: rtl/cnn_pkg.sv
// Shared constants and FSM state type for the CNN accelerator input path.
package cnn_pkg;

    localparam int                PIX_W    = 16;
    localparam int                ADDR_W   = 32;
    localparam int                IMG_PIX  = 784;
    localparam logic [ADDR_W-1:0] IMG_BASE = '0;
    localparam int                LANES    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/word_fifo.sv
// Small synchronous skid FIFO for host words. Head is the oldest entry and is
// visible combinationally; push while full and pop while empty are ignored.
module word_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] head_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    // Next pointers and occupancy; push and pop together leave the count unchanged.
    always_comb begin
        wr_ptr_d = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_ok ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state register; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Word storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/image_loader.sv
// Input-side writer: accepts host words, unpacks them into pixels and writes
// one pixel per cycle into the data buffer; pulses load_done_o per image.
module image_loader #(
    parameter int                         PIX_W      = cnn_pkg::PIX_W,
    parameter int                         WORD_W     = cnn_pkg::LANES * cnn_pkg::PIX_W,
    parameter int                         N_PIX      = cnn_pkg::IMG_PIX,
    parameter logic [cnn_pkg::ADDR_W-1:0] BASE_ADDR  = cnn_pkg::IMG_BASE,
    parameter int                         FIFO_DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start_i,
    input  logic                        data_in_valid,
    input  logic [WORD_W-1:0]           data_in,
    output logic                        data_in_ready,
    output logic                        buf_we_o,
    output logic [cnn_pkg::ADDR_W-1:0]  buf_wr_addr_o,
    output logic [PIX_W-1:0]            buf_din_o,
    output logic                        busy_o,
    output logic                        load_done_o
);

    import cnn_pkg::*;

    localparam int                LANE_N   = WORD_W / PIX_W;
    localparam int                LANE_W   = (LANE_N > 1) ? $clog2(LANE_N) : 1;
    localparam int                N_WORDS  = (N_PIX + LANE_N - 1) / LANE_N;
    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(N_PIX - 1);
    localparam logic [ADDR_W-1:0] WORD_LIM = ADDR_W'(N_WORDS);
    localparam logic [LANE_W-1:0] LAST_LN  = LANE_W'(LANE_N - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   word_cnt_q, word_cnt_d;
    logic [ADDR_W-1:0]   pix_cnt_q, pix_cnt_d;
    logic [LANE_W-1:0]   lane_cnt_q, lane_cnt_d;
    logic                fifo_full, fifo_empty;
    logic                push, pop, wr_en, last_pix;
    logic [WORD_W-1:0]   head;
    logic [PIX_W-1:0]    lane_pix;

    // Ready depends only on registered state, never on data_in_valid.
    assign data_in_ready = (state_q == LOAD) && !fifo_full && (word_cnt_q < WORD_LIM);
    assign push          = data_in_valid && data_in_ready;

    assign wr_en    = (state_q == LOAD) && !fifo_empty;
    assign last_pix = (pix_cnt_q == LAST_PIX);
    // Head word retires after its top lane, or early on the image's final pixel.
    assign pop      = wr_en && ((lane_cnt_q == LAST_LN) || last_pix);

    word_fifo #(
        .W     (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (data_in),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Lane select from the head word; lane 0 sits in the low bits.
    always_comb begin
        lane_pix = head[int'(lane_cnt_q) * PIX_W +: PIX_W];
    end

    // Address and data are forced to zero whenever no write is issued.
    assign buf_we_o      = wr_en;
    assign buf_wr_addr_o = wr_en ? (BASE_ADDR + pix_cnt_q) : '0;
    assign buf_din_o     = wr_en ? lane_pix : '0;
    assign busy_o        = (state_q == LOAD);
    assign load_done_o   = (state_q == DONE);

    // Next-state logic for the FSM and the word/pixel/lane counters.
    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        pix_cnt_d  = pix_cnt_q;
        lane_cnt_d = lane_cnt_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d    = LOAD;
                    word_cnt_d = '0;
                    pix_cnt_d  = '0;
                    lane_cnt_d = '0;
                end
            end
            LOAD: begin
                if (push) begin
                    word_cnt_d = word_cnt_q + ADDR_W'(1);
                end
                if (wr_en) begin
                    pix_cnt_d  = pix_cnt_q + ADDR_W'(1);
                    lane_cnt_d = pop ? '0 : lane_cnt_q + LANE_W'(1);
                    if (last_pix) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM and counter registers; reset aborts any load in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            word_cnt_q <= '0;
            pix_cnt_q  <= '0;
            lane_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            pix_cnt_q  <= pix_cnt_d;
            lane_cnt_q <= lane_cnt_d;
        end
    end

endmodule

// File: tb/tb_image_loader.sv
// Self-checking bench for image_loader: a full-size instance (784 pixels,
// base 0) and a small tail instance (10 pixels, base 0x100).
`timescale 1ns/1ps
module tb_image_loader;

    localparam int          N_PIX   = 784;
    localparam int          N_WORDS = 196;
    localparam int          T_PIX   = 10;
    localparam int          T_WORDS = 3;
    localparam logic [31:0] T_BASE  = 32'h100;

    typedef struct packed {
        logic [31:0] a;
        logic [15:0] d;
    } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0, start_i = 1'b0, data_in_valid = 1'b0;
    logic [63:0] data_in = '0;
    logic        data_in_ready, buf_we_o, busy_o, load_done_o;
    logic [31:0] buf_wr_addr_o;
    logic [15:0] buf_din_o;

    logic        t_rst_n = 1'b0, t_start = 1'b0, t_vld = 1'b0;
    logic [63:0] t_din = '0;
    logic        t_ready, t_we, t_busy, t_done;
    logic [31:0] t_addr;
    logic [15:0] t_dout;

    image_loader dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start_i),
        .data_in_valid (data_in_valid),
        .data_in       (data_in),
        .data_in_ready (data_in_ready),
        .buf_we_o      (buf_we_o),
        .buf_wr_addr_o (buf_wr_addr_o),
        .buf_din_o     (buf_din_o),
        .busy_o        (busy_o),
        .load_done_o   (load_done_o)
    );

    image_loader #(
        .N_PIX     (T_PIX),
        .BASE_ADDR (T_BASE)
    ) dut_t (
        .clk           (clk),
        .rst_n         (t_rst_n),
        .start_i       (t_start),
        .data_in_valid (t_vld),
        .data_in       (t_din),
        .data_in_ready (t_ready),
        .buf_we_o      (t_we),
        .buf_wr_addr_o (t_addr),
        .buf_din_o     (t_dout),
        .busy_o        (t_busy),
        .load_done_o   (t_done)
    );

    wr_t sb[$];
    int  vec  = 0;
    int  miss = 0;

    function automatic logic [63:0] pat_word(input int w);
        logic [63:0] r;
        for (int k = 0; k < 4; k++) r[16*k +: 16] = 16'(4*w + k);
        return r;
    endfunction

    // Expected writes for one accepted word; lanes past the image end are dropped.
    function automatic void sb_push_word(input logic [63:0] word, input int w,
                                         input logic [31:0] base, input int npix);
        wr_t e;
        for (int k = 0; k < 4; k++) begin
            if (4*w + k < npix) begin
                e.a = base + 32'(4*w + k);
                e.d = word[16*k +: 16];
                sb.push_back(e);
            end
        end
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; start_i = 1'b0; data_in_valid = 1'b1; data_in = pat_word(7);
        repeat (3) @(posedge clk);
        @(negedge clk);
        vec++;
        if ({data_in_ready, buf_we_o, busy_o, load_done_o, buf_wr_addr_o, buf_din_o} !== 52'd0) begin
            miss++;
            $display("FAIL reset_outputs: got %h want 0",
                     {data_in_ready, buf_we_o, busy_o, load_done_o, buf_wr_addr_o, buf_din_o});
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            vec++;
            if ({data_in_ready, buf_we_o, busy_o, load_done_o, buf_wr_addr_o, buf_din_o} !== 52'd0) begin
                miss++;
                $display("FAIL idle_valid_ignored cycle %0d: got %h want 0", i,
                         {data_in_ready, buf_we_o, busy_o, load_done_o, buf_wr_addr_o, buf_din_o});
            end
        end
        data_in_valid = 1'b0;
    endtask

    task automatic test_nominal();
        int  w = 0, nwr = 0, ndone = 0, last_wr = -100;
        bit  took, fin = 0;
        wr_t e;
        sb.delete();
        @(negedge clk); start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        vec++;
        if (busy_o !== 1'b1) begin
            miss++; $display("FAIL nominal_busy: got %b want 1", busy_o);
        end
        data_in_valid = 1'b1; data_in = pat_word(0);
        for (int cyc = 0; cyc < 1500 && !fin; cyc++) begin
            took = data_in_valid && data_in_ready;
            if (took) begin sb_push_word(data_in, w, 32'd0, N_PIX); w++; end
            @(negedge clk);
            if (took && w == N_WORDS) begin
                vec++;
                if (data_in_ready !== 1'b0) begin
                    miss++; $display("FAIL nominal_ready_fall: got %b want 0", data_in_ready);
                end
            end
            if (buf_we_o === 1'b1) begin
                vec++;
                if (sb.size() == 0) begin
                    miss++; $display("FAIL nominal_extra_write: got addr=%h want no write", buf_wr_addr_o);
                end else begin
                    e = sb.pop_front();
                    if ({buf_wr_addr_o, buf_din_o} !== {e.a, e.d}) begin
                        miss++;
                        $display("FAIL nominal_write: got addr=%h data=%h want addr=%h data=%h",
                                 buf_wr_addr_o, buf_din_o, e.a, e.d);
                    end
                end
                if (buf_wr_addr_o == 32'd783) last_wr = cyc;
                nwr++;
            end
            if (load_done_o === 1'b1) begin
                ndone++; vec++;
                if (cyc != last_wr + 1) begin
                    miss++; $display("FAIL nominal_done_timing: got cycle %0d want %0d", cyc, last_wr + 1);
                end
            end
            if (ndone != 0 && cyc >= last_wr + 4) fin = 1;
            if (took) begin
                if (w < N_WORDS) data_in = pat_word(w);
                else data_in_valid = 1'b0;
            end
        end
        vec++;
        if (nwr != N_PIX || ndone != 1 || sb.size() != 0 || busy_o !== 1'b0) begin
            miss++;
            $display("FAIL nominal_totals: got writes=%0d done=%0d left=%0d busy=%b want 784/1/0/0",
                     nwr, ndone, sb.size(), busy_o);
        end
    endtask

    task automatic test_backpressure();
        int  w = 0, nwr = 0, ndone = 0, occ = 0, last_wr = -100;
        bit  took, popped = 0, fin = 0, burst;
        wr_t e;
        sb.delete();
        @(negedge clk); start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        data_in_valid = 1'b0;
        for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
            burst = ((cyc / 40) % 2) == 0;
            if (!data_in_valid && w < N_WORDS && (burst || $urandom_range(0, 3) == 0)) begin
                data_in_valid = 1'b1;
                data_in = {$urandom, $urandom};
            end
            took = data_in_valid && data_in_ready;
            if (took) begin sb_push_word(data_in, w, 32'd0, N_PIX); w++; end
            @(negedge clk);
            occ = occ + int'(took) - int'(popped);
            popped = 1'b0;
            if (nwr < N_PIX) begin
                vec++;
                if (data_in_ready !== (occ < 2 && w < N_WORDS)) begin
                    miss++; $display("FAIL bp_ready: got %b want %b (occ %0d)", data_in_ready, (occ < 2 && w < N_WORDS), occ);
                end
                vec++;
                if (buf_we_o !== (occ != 0)) begin
                    miss++; $display("FAIL bp_contiguous: got we=%b want %b (occ %0d)", buf_we_o, (occ != 0), occ);
                end
            end
            if (buf_we_o === 1'b1) begin
                vec++;
                if (sb.size() == 0) begin
                    miss++; $display("FAIL bp_extra_write: got addr=%h want no write", buf_wr_addr_o);
                end else begin
                    e = sb.pop_front();
                    if ({buf_wr_addr_o, buf_din_o} !== {e.a, e.d}) begin
                        miss++;
                        $display("FAIL bp_write: got addr=%h data=%h want addr=%h data=%h",
                                 buf_wr_addr_o, buf_din_o, e.a, e.d);
                    end
                end
                if (nwr % 4 == 3) popped = 1'b1;
                if (nwr == N_PIX - 1) last_wr = cyc;
                nwr++;
            end
            if (load_done_o === 1'b1) ndone++;
            if (ndone != 0 && cyc >= last_wr + 3) fin = 1;
            if (took) data_in_valid = 1'b0;
        end
        data_in_valid = 1'b0;
        vec++;
        if (nwr != N_PIX || ndone != 1 || sb.size() != 0) begin
            miss++;
            $display("FAIL bp_totals: got writes=%0d done=%0d left=%0d want 784/1/0", nwr, ndone, sb.size());
        end
    endtask

    task automatic test_tail();
        int  w = 0, nwr = 0, ndone = 0, last_wr = -100;
        bit  took;
        wr_t e;
        sb.delete();
        t_rst_n = 1'b0;
        repeat (2) @(negedge clk);
        t_rst_n = 1'b1;
        @(negedge clk); t_start = 1'b1;
        @(negedge clk); t_start = 1'b0;
        t_vld = 1'b1; t_din = pat_word(0);
        for (int cyc = 0; cyc < 60; cyc++) begin
            took = t_vld && t_ready;
            if (took) begin sb_push_word(t_din, w, T_BASE, T_PIX); w++; end
            @(negedge clk);
            if (took && w == T_WORDS) begin
                vec++;
                if (t_ready !== 1'b0) begin
                    miss++; $display("FAIL tail_ready_fall: got %b want 0", t_ready);
                end
            end
            if (t_we === 1'b1) begin
                vec++;
                if (sb.size() == 0) begin
                    miss++; $display("FAIL tail_extra_write: got addr=%h data=%h want no write", t_addr, t_dout);
                end else begin
                    e = sb.pop_front();
                    if ({t_addr, t_dout} !== {e.a, e.d}) begin
                        miss++;
                        $display("FAIL tail_write: got addr=%h data=%h want addr=%h data=%h", t_addr, t_dout, e.a, e.d);
                    end
                end
                if (t_addr == T_BASE + 32'd9) last_wr = cyc;
                nwr++;
            end
            if (t_done === 1'b1) begin
                ndone++; vec++;
                if (cyc != last_wr + 1) begin
                    miss++; $display("FAIL tail_done_timing: got cycle %0d want %0d", cyc, last_wr + 1);
                end
            end
            if (took) t_din = pat_word(w);
        end
        t_vld = 1'b0;
        vec++;
        if (w != T_WORDS || nwr != T_PIX || ndone != 1 || sb.size() != 0) begin
            miss++;
            $display("FAIL tail_totals: got words=%0d writes=%0d done=%0d left=%0d want 3/10/1/0",
                     w, nwr, ndone, sb.size());
        end
    endtask

    task automatic test_reset_mid_load();
        int  w = 0, nwr = 0;
        bit  took;
        wr_t e;
        sb.delete();
        @(negedge clk); start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        data_in_valid = 1'b1; data_in = pat_word(0);
        for (int cyc = 0; cyc < 400 && w < 50; cyc++) begin
            took = data_in_valid && data_in_ready;
            if (took) begin sb_push_word(data_in, w, 32'd0, N_PIX); w++; end
            @(negedge clk);
            if (buf_we_o === 1'b1 && sb.size() != 0) begin
                e = sb.pop_front();
                vec++;
                if ({buf_wr_addr_o, buf_din_o} !== {e.a, e.d}) begin
                    miss++;
                    $display("FAIL abort_prefix_write: got addr=%h data=%h want addr=%h data=%h",
                             buf_wr_addr_o, buf_din_o, e.a, e.d);
                end
            end
            if (took) data_in = pat_word(w);
        end
        rst_n = 1'b0; data_in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 1) rst_n = 1'b1;
            vec++;
            if ({data_in_ready, buf_we_o, busy_o, load_done_o, buf_wr_addr_o, buf_din_o} !== 52'd0) begin
                miss++;
                $display("FAIL abort_outputs cycle %0d: got %h want 0", i,
                         {data_in_ready, buf_we_o, busy_o, load_done_o, buf_wr_addr_o, buf_din_o});
            end
        end
        sb.delete(); w = 0;
        start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        data_in_valid = 1'b1; data_in = pat_word(0);
        for (int cyc = 0; cyc < 20; cyc++) begin
            took = data_in_valid && data_in_ready;
            if (took) begin sb_push_word(data_in, w, 32'd0, N_PIX); w++; end
            @(negedge clk);
            if (buf_we_o === 1'b1) begin
                vec++;
                if (sb.size() == 0) begin
                    miss++; $display("FAIL reload_extra_write: got addr=%h want no write", buf_wr_addr_o);
                end else begin
                    e = sb.pop_front();
                    if ({buf_wr_addr_o, buf_din_o} !== {e.a, e.d}) begin
                        miss++;
                        $display("FAIL reload_write: got addr=%h data=%h want addr=%h data=%h",
                                 buf_wr_addr_o, buf_din_o, e.a, e.d);
                    end
                end
                nwr++;
            end
            if (took) begin
                if (w < 2) data_in = pat_word(w);
                else data_in_valid = 1'b0;
            end
        end
        vec++;
        if (nwr != 8 || load_done_o !== 1'b0 || busy_o !== 1'b1) begin
            miss++;
            $display("FAIL reload_totals: got writes=%0d done=%b busy=%b want 8/0/1", nwr, load_done_o, busy_o);
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_start_ignored();
        int w = 0, nwr = 0, ndone = 0, after = 0;
        bit took, fin = 0, done_prev = 0;
        @(negedge clk); start_i = 1'b1;
        @(negedge clk);
        data_in_valid = 1'b1; data_in = pat_word(0);
        for (int cyc = 0; cyc < 1500 && !fin; cyc++) begin
            took = data_in_valid && data_in_ready;
            if (took) w++;
            @(negedge clk);
            if (done_prev) begin
                start_i = 1'b0;
                vec++;
                if (busy_o !== 1'b0) begin
                    miss++; $display("FAIL start_in_done_restarts: got busy=%b want 0", busy_o);
                end
            end
            if (buf_we_o === 1'b1) begin
                vec++;
                if (buf_wr_addr_o !== 32'(nwr) || buf_din_o !== 16'(nwr)) begin
                    miss++;
                    $display("FAIL start_write: got addr=%h data=%h want %h", buf_wr_addr_o, buf_din_o, nwr);
                end
                nwr++;
            end
            done_prev = (load_done_o === 1'b1);
            if (done_prev) ndone++;
            if (ndone != 0) after++;
            if (after > 10) fin = 1;
            if (took) begin
                if (w < N_WORDS) data_in = pat_word(w);
                else data_in_valid = 1'b0;
            end
        end
        start_i = 1'b0; data_in_valid = 1'b0;
        vec++;
        if (ndone != 1 || nwr != N_PIX || busy_o !== 1'b0) begin
            miss++;
            $display("FAIL start_totals: got done=%0d writes=%0d busy=%b want 1/784/0", ndone, nwr, busy_o);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_tail();
        test_reset_mid_load();
        test_start_ignored();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
